// File: rtl/vector_dot_multi_if.sv
// Valid/ready stream bundle shared by the vector_dot_multi ports.
// W sets the tdata width of each stream instance.
interface vector_dot_multi_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/vector_dot_multi.sv
// Streaming multi-lane signed dot product, one result per length-word row.
// Define VECDOT_SAT_EN for saturating accumulation and the tuser overflow flag.
module vector_dot_multi #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int LEN_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    vector_dot_multi_if.slave  S_AXIS_A,
    vector_dot_multi_if.slave  S_AXIS_B,
    vector_dot_multi_if.slave  S_AXIS_TIMES,
    vector_dot_multi_if.master M_AXIS_OUT
`ifdef VECDOT_SAT_EN
    ,
    output logic               M_AXIS_OUT_tuser
`endif
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int EXT_W  = (SUM_W > ACC_W) ? SUM_W : ACC_W;
    // One spare bit so acc+sum never overflows before the wrap/clamp step.
    localparam int TW     = EXT_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZERO
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_stall;
    logic w_len_hs;
    logic w_beat;
    logic w_zero_emit;
    logic w_row_done;

    logic [LEN_W-1:0] r_rem;
    logic             r_first;

    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [PROD_W-1:0] r_prod [LANES];
    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;

    logic signed [EXT_W-1:0] w_sum;
    logic signed [TW-1:0]    w_total;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out_data;
    logic                    r_out_valid;

    assign w_stall = r_out_valid & ~M_AXIS_OUT.tready;

    assign S_AXIS_TIMES.tready = (r_state == IDLE) & ~w_stall & ~rst;
    assign S_AXIS_A.tready = (r_state == RUN) & ~w_stall
                           & S_AXIS_B.tvalid & ~rst;
    assign S_AXIS_B.tready = (r_state == RUN) & ~w_stall
                           & S_AXIS_A.tvalid & ~rst;

    assign w_len_hs    = S_AXIS_TIMES.tvalid & S_AXIS_TIMES.tready;
    assign w_beat      = S_AXIS_A.tvalid & S_AXIS_A.tready;
    assign w_zero_emit = (r_state == ZERO) & ~r_s1_valid & ~w_stall;
    assign w_row_done  = r_s1_valid & r_s1_last;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_len_hs) begin
                    w_next = (S_AXIS_TIMES.tdata != '0) ? RUN : ZERO;
                end
            end
            RUN: begin
                if (w_beat && r_rem == LEN_W'(1)) begin
                    w_next = IDLE;
                end
            end
            ZERO: begin
                if (w_zero_emit) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_first <= 1'b0;
        end else if (w_len_hs) begin
            r_rem   <= S_AXIS_TIMES.tdata;
            r_first <= 1'b1;
        end else if (w_beat) begin
            r_rem   <= r_rem - LEN_W'(1);
            r_first <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = PROD_W'($signed(S_AXIS_A.tdata[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(S_AXIS_B.tdata[i*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else if (!w_stall) begin
            r_s1_valid <= w_beat;
            if (w_beat) begin
                r_s1_first <= r_first;
                r_s1_last  <= (r_rem == LEN_W'(1));
                for (int i = 0; i < LANES; i++) begin
                    r_prod[i] <= w_prod[i];
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + EXT_W'(r_prod[i]);
        end
    end

    // FIRST reloads the accumulator so rows chain without a clear cycle.
    assign w_total = r_s1_first ? TW'(w_sum) : TW'(r_acc) + TW'(w_sum);

`ifdef VECDOT_SAT_EN
    localparam logic signed [TW-1:0] MAXV = TW'((TW'(1) << (ACC_W - 1)) - TW'(1));
    localparam logic signed [TW-1:0] MINV = TW'(-(TW'(1) << (ACC_W - 1)));

    logic w_ovf;
    logic w_sat_next;
    logic r_sat;
    logic r_out_user;

    always_comb begin
        w_ovf      = 1'b0;
        w_acc_next = w_total[ACC_W-1:0];
        if (w_total > MAXV) begin
            w_ovf      = 1'b1;
            w_acc_next = MAXV[ACC_W-1:0];
        end else if (w_total < MINV) begin
            w_ovf      = 1'b1;
            w_acc_next = MINV[ACC_W-1:0];
        end
    end

    assign w_sat_next = (r_s1_first ? 1'b0 : r_sat) | w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat      <= 1'b0;
            r_out_user <= 1'b0;
        end else if (!w_stall) begin
            if (r_s1_valid) begin
                r_sat <= w_sat_next;
            end
            if (w_row_done) begin
                r_out_user <= w_sat_next;
            end else if (w_zero_emit) begin
                r_out_user <= 1'b0;
            end
        end
    end

    assign M_AXIS_OUT_tuser = r_out_user;
`else
    assign w_acc_next = w_total[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
            end
            r_out_valid <= w_row_done | w_zero_emit;
            if (w_row_done) begin
                r_out_data <= w_acc_next;
            end else if (w_zero_emit) begin
                r_out_data <= '0;
            end
        end
    end

    assign M_AXIS_OUT.tvalid = r_out_valid;
    assign M_AXIS_OUT.tdata  = r_out_data;
endmodule

// File: tb/tb_vector_dot_multi.sv
// Directed bench for vector_dot_multi (LANES=4, DATA_W=16, ACC_W=32).
// Build with or without VECDOT_SAT_EN; the overflow row expectation follows it.
module tb_vector_dot_multi;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int LW    = 32;
    localparam int BW    = LANES * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic user_w;

    always #5 clk = ~clk;

    vector_dot_multi_if #(.W(BW)) a_if ();
    vector_dot_multi_if #(.W(BW)) b_if ();
    vector_dot_multi_if #(.W(LW)) t_if ();
    vector_dot_multi_if #(.W(AW)) o_if ();

    vector_dot_multi #(
        .LANES (LANES),
        .DATA_W(DW),
        .ACC_W (AW),
        .LEN_W (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .S_AXIS_A    (a_if),
        .S_AXIS_B    (b_if),
        .S_AXIS_TIMES(t_if),
`ifdef VECDOT_SAT_EN
        .M_AXIS_OUT  (o_if),
        .M_AXIS_OUT_tuser(user_w)
`else
        .M_AXIS_OUT  (o_if)
`endif
    );

`ifndef VECDOT_SAT_EN
    assign user_w = 1'b0;
`endif

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } beat_t;

    typedef struct {
        logic [AW-1:0] d;
        logic          u;
        int            cyc;
    } res_t;

    beat_t      beat_q[$];
    logic [LW-1:0] len_q[$];
    res_t       out_q[$];
    int         beat_cyc_q[$];
    int         len_cyc_q[$];
    int         cyc = 0;
    int         beats_acc = 0;
    int         rise_cyc = -1;
    int         total = 0;
    int         bad = 0;

    function automatic logic [BW-1:0] pk(input int x0, input int x1,
                                         input int x2, input int x3);
        return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
    endfunction

    // Stream driver and handshake monitor.
    initial begin
        bit   t_acc;
        bit   b_acc;
        logic prev_v;
        prev_v = 1'b0;
        t_if.tvalid = 1'b0;
        t_if.tdata  = '0;
        a_if.tvalid = 1'b0;
        a_if.tdata  = '0;
        b_if.tvalid = 1'b0;
        b_if.tdata  = '0;
        forever begin
            @(negedge clk);
            t_acc = t_if.tvalid && t_if.tready;
            b_acc = a_if.tvalid && a_if.tready && b_if.tvalid && b_if.tready;
            if (t_acc) len_cyc_q.push_back(cyc);
            if (b_acc) begin
                beat_cyc_q.push_back(cyc);
                beats_acc++;
            end
            if (o_if.tvalid && o_if.tready)
                out_q.push_back('{o_if.tdata, user_w, cyc});
            if (o_if.tvalid && !prev_v) rise_cyc = cyc;
            prev_v = o_if.tvalid;
            @(posedge clk);
            cyc++;
            #1;
            if (t_acc && len_q.size() > 0) void'(len_q.pop_front());
            if (b_acc && beat_q.size() > 0) void'(beat_q.pop_front());
            if (len_q.size() > 0) begin
                t_if.tvalid = 1'b1;
                t_if.tdata  = len_q[0];
            end else begin
                t_if.tvalid = 1'b0;
            end
            if (beat_q.size() > 0) begin
                a_if.tvalid = 1'b1;
                b_if.tvalid = 1'b1;
                a_if.tdata  = beat_q[0].a;
                b_if.tdata  = beat_q[0].b;
            end else begin
                a_if.tvalid = 1'b0;
                b_if.tvalid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        out_q.delete();
        beat_cyc_q.delete();
        len_cyc_q.delete();
    endtask

    task automatic test_reset();
        o_if.tready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (t_if.tready !== 1'b0 || a_if.tready !== 1'b0 || b_if.tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_tready: times=%b a=%b b=%b want 0",
                     t_if.tready, a_if.tready, b_if.tready);
        end
        total++;
        if (o_if.tvalid !== 1'b0 || o_if.tdata !== '0 || user_w !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: tvalid=%b tdata=%h tuser=%b want 0/0/0",
                     o_if.tvalid, o_if.tdata, user_w);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (t_if.tready !== 1'b1) begin
            bad++;
            $display("FAIL idle_times_ready: got %b want 1", t_if.tready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        step();
        clear_logs();
        len_q.push_back(LW'(2));
        beat_q.push_back('{pk(1, 2, 3, 4), pk(1, 1, 1, 1)});
        beat_q.push_back('{pk(5, 6, 7, 8), pk(1, 1, 1, 1)});
        wait_out(1, 50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout: got %0d results want 1", out_q.size());
        end else begin
            total++;
            if (out_q[0].d !== 32'd36) begin
                bad++;
                $display("FAIL basic_sum: got %0d want 36", $signed(out_q[0].d));
            end
            total++;
            if (beat_cyc_q.size() != 2 || rise_cyc != beat_cyc_q[1] + 2) begin
                bad++;
                $display("FAIL basic_latency: beats=%0d rise=%0d want last_beat+2",
                         beat_cyc_q.size(), rise_cyc);
            end
`ifdef VECDOT_SAT_EN
            total++;
            if (out_q[0].u !== 1'b0) begin
                bad++;
                $display("FAIL basic_tuser: got %b want 0", out_q[0].u);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [BW-1:0] m1;
        m1 = pk(-1, -1, -1, -1);
        step();
        clear_logs();
        len_q.push_back(LW'(3));
        len_q.push_back(LW'(1));
        repeat (4) beat_q.push_back('{m1, m1});
        wait_out(2, 50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d results want 2", out_q.size());
        end else begin
            total++;
            if (out_q[0].d !== 32'd12 || out_q[1].d !== 32'd4) begin
                bad++;
                $display("FAIL b2b_sums: got %0d,%0d want 12,4",
                         $signed(out_q[0].d), $signed(out_q[1].d));
            end
            total++;
            if (beat_cyc_q.size() != 4 || len_cyc_q.size() != 2 ||
                beat_cyc_q[2] != beat_cyc_q[0] + 2 ||
                len_cyc_q[1] != beat_cyc_q[2] + 1 ||
                beat_cyc_q[3] != len_cyc_q[1] + 1) begin
                bad++;
                $display("FAIL b2b_spacing: beats=%0d lens=%0d want dense 3-beat row, len next cycle, beat after",
                         beat_cyc_q.size(), len_cyc_q.size());
            end
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        step();
        clear_logs();
        len_q.push_back(LW'(2));
        beat_q.push_back('{pk(3, -2, 1, 0), pk(4, 5, -6, 7)});
        beat_q.push_back('{pk(100, 200, -300, 400), pk(1, 1, 1, 1)});
        len_q.push_back(LW'(0));
        wait_out(2, 50, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL zero_timeout: got %0d results want 2", out_q.size());
        end else begin
            total++;
            if (out_q[0].d !== 32'd396) begin
                bad++;
                $display("FAIL zero_row_sum: got %0d want 396", $signed(out_q[0].d));
            end
            total++;
            if (out_q[1].d !== 32'd0 || out_q[1].u !== 1'b0) begin
                bad++;
                $display("FAIL zero_result: got %0d tuser %b want 0/0",
                         $signed(out_q[1].d), out_q[1].u);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [AW-1:0] hold;
        logic [AW-1:0] e0;
        logic [AW-1:0] e1;
        int start;
        e0 = 32'(-26);
        e1 = 32'(-100);
        step();
        clear_logs();
        start = beats_acc;
        o_if.tready = 1'b0;
        len_q.push_back(LW'(2));
        beat_q.push_back('{pk(1000, -1000, 2, 3), pk(3, 3, 4, 5)});
        beat_q.push_back('{pk(-7, 0, 0, 0), pk(7, 1, 1, 1)});
        len_q.push_back(LW'(1));
        beat_q.push_back('{pk(10, 10, 10, 10), pk(-1, -2, -3, -4)});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_if.tvalid) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_timeout: tvalid never rose");
        end
        hold = o_if.tdata;
        total++;
        if (hold !== e0) begin
            bad++;
            $display("FAIL stall_held_value: got %0d want -26", $signed(hold));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (a_if.tready !== 1'b0 || b_if.tready !== 1'b0 ||
                t_if.tready !== 1'b0 || o_if.tvalid !== 1'b1 ||
                o_if.tdata !== hold) begin
                bad++;
                $display("FAIL stall_hold_%0d: a=%b b=%b t=%b v=%b d=%0d want 0 0 0 1 %0d",
                         i, a_if.tready, b_if.tready, t_if.tready,
                         o_if.tvalid, $signed(o_if.tdata), $signed(hold));
            end
        end
        step();
        o_if.tready = 1'b1;
        wait_out(2, 50, ok);
        total++;
        if (!ok || out_q[0].d !== e0 || out_q[1].d !== e1 ||
            beats_acc - start != 3) begin
            bad++;
            $display("FAIL stall_resume: n=%0d beats=%0d want 2 results -26,-100 and 3 beats",
                     out_q.size(), beats_acc - start);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int start;
        step();
        clear_logs();
        start = beats_acc;
        len_q.push_back(LW'(5));
        beat_q.push_back('{pk(9, 9, 9, 9), pk(9, 9, 9, 9)});
        beat_q.push_back('{pk(9, 9, 9, 9), pk(9, 9, 9, 9)});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (beats_acc - start >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_timeout: beats=%0d want 2", beats_acc - start);
        end
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (t_if.tready !== 1'b0 || o_if.tvalid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_during: times_ready=%b tvalid=%b want 0 0",
                     t_if.tready, o_if.tvalid);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (o_if.tvalid !== 1'b0 || out_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_after: tvalid=%b results=%0d want 0 0",
                     o_if.tvalid, out_q.size());
        end
        step();
        len_q.push_back(LW'(1));
        beat_q.push_back('{pk(2, 0, 0, 0), pk(2, 0, 0, 0)});
        wait_out(1, 50, ok);
        total++;
        if (!ok || out_q[0].d !== 32'd4) begin
            bad++;
            $display("FAIL rstmid_fresh_row: n=%0d want one result of 4", out_q.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        longint p;
        logic [AW-1:0] e;
        logic [BW-1:0] mx;
        mx = pk(32767, 32767, 32767, 32767);
        p = 64'd4 * 64'd32767 * 64'd32767 * 64'd70000;
`ifdef VECDOT_SAT_EN
        e = 32'h7fff_ffff;
`else
        e = p[AW-1:0];
`endif
        step();
        clear_logs();
        len_q.push_back(LW'(70000));
        for (int i = 0; i < 70000; i++) beat_q.push_back('{mx, mx});
        wait_out(1, 70200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovf_timeout: got %0d results want 1", out_q.size());
        end else begin
            total++;
            if (out_q[0].d !== e) begin
                bad++;
                $display("FAIL ovf_value: got %0d want %0d",
                         $signed(out_q[0].d), $signed(e));
            end
`ifdef VECDOT_SAT_EN
            total++;
            if (out_q[0].u !== 1'b1) begin
                bad++;
                $display("FAIL ovf_tuser: got %b want 1", out_q[0].u);
            end
`endif
        end
    endtask

    initial begin
        o_if.tready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_len();
        test_stall();
        test_reset_mid();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
